// File: rtl/scalar_vector_mult_seq_if.sv
// ---------------------------------------------------------------------------
// scalar_vector_mult_seq_if
//   Handshake/data bundle for the time-multiplexed scalar x vector multiplier.
//   master : producer of operands and consumer of results (drives in_valid,
//            scalar, in_vector, out_ready)
//   slave  : the multiplier (drives in_ready, out_valid, out_vector, ovf, busy)
//   Element i of in_vector/out_vector sits at bits [i*TOTAL_WIDTH +: TOTAL_WIDTH].
// ---------------------------------------------------------------------------
interface scalar_vector_mult_seq_if #(
   parameter int TOTAL_WIDTH = 32,
   parameter int VECTOR_SIZE = 8
);
   logic                               in_valid;
   logic                               in_ready;
   logic [TOTAL_WIDTH-1:0]             scalar;
   logic [TOTAL_WIDTH*VECTOR_SIZE-1:0] in_vector;
   logic                               out_valid;
   logic                               out_ready;
   logic [TOTAL_WIDTH*VECTOR_SIZE-1:0] out_vector;
   logic [VECTOR_SIZE-1:0]             ovf;
   logic                               busy;

   modport master (
      output in_valid, scalar, in_vector, out_ready,
      input  in_ready, out_valid, out_vector, ovf, busy
   );

   modport slave (
      input  in_valid, scalar, in_vector, out_ready,
      output in_ready, out_valid, out_vector, ovf, busy
   );
endinterface

// File: rtl/scalar_vector_mult_seq.sv
// ---------------------------------------------------------------------------
// scalar_vector_mult_seq
//   Fixed-point scalar x vector multiplier. LANES signed multipliers are shared
//   over VECTOR_SIZE elements, one chunk of LANES elements per cycle. Products
//   are rounded half-up, shifted right by FRAC_WIDTH and narrowed back to
//   TOTAL_WIDTH.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset (aborts any operation in flight)
//     bus  - scalar_vector_mult_seq_if.slave: in_valid/in_ready operand
//            handshake, out_valid/out_ready result handshake, out_vector,
//            per-element ovf flags, busy (high in MULT or DONE)
//
//   Build option:
//     SVM_SATURATE_EN - when defined, results outside the signed TOTAL_WIDTH
//                       range saturate and raise ovf[i]; when undefined they
//                       wrap and ovf stays 0.
// ---------------------------------------------------------------------------
module scalar_vector_mult_seq #(
   parameter int TOTAL_WIDTH = 32,
   parameter int FRAC_WIDTH  = 16,
   parameter int VECTOR_SIZE = 8,
   parameter int LANES       = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   scalar_vector_mult_seq_if.slave   bus
);
   localparam int N_CHUNKS = VECTOR_SIZE / LANES;
   localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam int IW       = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
   localparam int PW       = 2 * TOTAL_WIDTH;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(N_CHUNKS - 1);
   // Half an LSB of the result; zero in integer mode
   localparam logic signed [PW-1:0] ROUND_C = $signed((PW'(1'b1) << FRAC_WIDTH) >> 1);
`ifdef SVM_SATURATE_EN
   localparam logic signed [PW-1:0] SAT_MAX =
      $signed({{(TOTAL_WIDTH + 1){1'b0}}, {(TOTAL_WIDTH - 1){1'b1}}});
   localparam logic signed [PW-1:0] SAT_MIN =
      $signed({{(TOTAL_WIDTH + 1){1'b1}}, {(TOTAL_WIDTH - 1){1'b0}}});
`endif

   generate
      if ((LANES < 1) || ((VECTOR_SIZE % LANES) != 0)) begin : g_bad_lanes
         $error("LANES must divide VECTOR_SIZE");
      end
      if ((FRAC_WIDTH < 0) || (FRAC_WIDTH >= TOTAL_WIDTH)) begin : g_bad_frac
         $error("FRAC_WIDTH must be in [0, TOTAL_WIDTH)");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns {ovf, result} for one element: full product, round, shift, narrow
   function automatic logic [TOTAL_WIDTH:0] mul_fix(
      input logic [TOTAL_WIDTH-1:0] a,
      input logic [TOTAL_WIDTH-1:0] b
   );
      logic signed [PW-1:0] p;
      logic signed [PW-1:0] r;
      p = $signed(a) * $signed(b);
      p = p + ROUND_C;
      r = p >>> FRAC_WIDTH;
`ifdef SVM_SATURATE_EN
      if (r > SAT_MAX) begin
         return {1'b1, 1'b0, {(TOTAL_WIDTH - 1){1'b1}}};
      end else if (r < SAT_MIN) begin
         return {1'b1, 1'b1, {(TOTAL_WIDTH - 1){1'b0}}};
      end else begin
         return {1'b0, TOTAL_WIDTH'(r)};
      end
`else
      return {1'b0, TOTAL_WIDTH'(r)};
`endif
   endfunction

   state_t                                  state_r, state_s;
   logic [CW-1:0]                           chunk_r, chunk_s;
   logic                                    accept_s;
   logic                                    out_valid_r, out_valid_s;
   logic                                    in_ready_r;
   logic                                    busy_r;
   logic [TOTAL_WIDTH-1:0]                  scalar_r;
   logic [VECTOR_SIZE-1:0][TOTAL_WIDTH-1:0] vec_r;
   logic [VECTOR_SIZE-1:0][TOTAL_WIDTH-1:0] out_vec_r;
   logic [VECTOR_SIZE-1:0]                  ovf_r;
   logic [LANES-1:0][IW-1:0]                lane_idx_s;
   logic [LANES-1:0][TOTAL_WIDTH:0]         lane_res_s;

   // FSM state register plus handshake/status outputs registered from next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         chunk_r     <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         chunk_r     <= chunk_s;
         out_valid_r <= out_valid_s;
         in_ready_r  <= (state_s == ST_IDLE);
         busy_r      <= (state_s != ST_IDLE);
      end
   end

   // FSM next-state: accept in IDLE, sweep chunks in MULT, hold result in DONE
   always_comb begin
      state_s     = state_r;
      chunk_s     = chunk_r;
      accept_s    = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            chunk_s = '0;
            if (bus.in_valid && in_ready_r) begin
               accept_s = 1'b1;
               state_s  = ST_MULT;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_MULT: begin
            if (chunk_r == LAST_CHUNK) begin
               chunk_s = '0;
               state_s = ST_DONE;
            end else begin
               chunk_s = chunk_r + CW'(1'b1);
               state_s = ST_MULT;
            end
         end
         ST_DONE: begin
            // out_valid rises one cycle into DONE, after the last chunk is stable
            if (out_valid_r && bus.out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s     = ST_DONE;
               out_valid_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
            chunk_s = '0;
         end
      endcase
   end

   // Shared multipliers: lane l works on element chunk*LANES + l
   always_comb begin
      lane_idx_s = '0;
      lane_res_s = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_idx_s[l] = IW'(int'(chunk_r) * LANES + l);
         lane_res_s[l] = mul_fix(scalar_r, vec_r[lane_idx_s[l]]);
      end
   end

   // Operand capture on accept and per-chunk write-back of results and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         scalar_r  <= '0;
         vec_r     <= '0;
         out_vec_r <= '0;
         ovf_r     <= '0;
      end else begin
         if (accept_s) begin
            scalar_r <= bus.scalar;
            vec_r    <= bus.in_vector;
         end
         if (state_r == ST_MULT) begin
            for (int l = 0; l < LANES; l++) begin
               out_vec_r[lane_idx_s[l]] <= lane_res_s[l][TOTAL_WIDTH-1:0];
               ovf_r[lane_idx_s[l]]     <= lane_res_s[l][TOTAL_WIDTH];
            end
         end
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_vector = out_vec_r;
   assign bus.ovf        = ovf_r;
   assign bus.busy       = busy_r;
endmodule

// File: tb/tb_scalar_vector_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_scalar_vector_mult_seq
//   Bench for scalar_vector_mult_seq. dut_a: Q16.16, VECTOR_SIZE=8, LANES=2.
//   dut_b: integer mode, LANES=8 (one chunk). Expected results come from a
//   plain 64-bit arithmetic reference; a scoreboard queue holds one entry per
//   accepted operation and is checked whenever dut_a presents out_valid.
// ---------------------------------------------------------------------------
module tb_scalar_vector_mult_seq;
   typedef struct packed {
      logic [255:0] vec;
      logic [7:0]   ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   rand_rdy = 1'b0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   scalar_vector_mult_seq_if #(.TOTAL_WIDTH(32), .VECTOR_SIZE(8)) ifa ();
   scalar_vector_mult_seq_if #(.TOTAL_WIDTH(32), .VECTOR_SIZE(8)) ifb ();

   scalar_vector_mult_seq #(.TOTAL_WIDTH(32), .FRAC_WIDTH(16), .VECTOR_SIZE(8), .LANES(2))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   scalar_vector_mult_seq #(.TOTAL_WIDTH(32), .FRAC_WIDTH(0), .VECTOR_SIZE(8), .LANES(8))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));

   // Reference: {ovf, result} for one element
   function automatic logic [32:0] ref_mul(input logic [31:0] s, input logic [31:0] e, input int frac);
      longint p;
      longint r;
      p = longint'($signed(s)) * longint'($signed(e));
      if (frac > 0) p = p + (longint'(1) <<< (frac - 1));
      r = p >>> frac;
`ifdef SVM_SATURATE_EN
      if (r > 64'sh7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
      if (r < -64'sh8000_0000) return {1'b1, 32'h8000_0000};
`endif
      return {1'b0, r[31:0]};
   endfunction

   function automatic exp_t ref_vec(input logic [31:0] s, input logic [255:0] v, input int frac);
      exp_t       x;
      logic [32:0] y;
      for (int i = 0; i < 8; i++) begin
         y = ref_mul(s, v[i*32 +: 32], frac);
         x.vec[i*32 +: 32] = y[31:0];
         x.ovf[i] = y[32];
      end
      return x;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Scoreboard: push on operand accept, pop on result handshake, flush on reset
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (ifa.out_valid && ifa.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (ifa.in_valid && ifa.in_ready) exp_q.push_back(ref_vec(ifa.scalar, ifa.in_vector, 16));
      end
   end

   // Compare process: every cycle dut_a shows a result, it must match the model
   always @(negedge clk) begin
      if (!rst && ifa.out_valid) begin
         if (exp_q.size() == 0) begin
            fail("spurious_out_valid");
         end else begin
            check("out_vector", ifa.out_vector, exp_q[0].vec);
            check("ovf", ifa.ovf, exp_q[0].ovf);
            check("busy_in_ready_in_done", {ifa.busy, ifa.in_ready}, 2'b10);
         end
      end
   end

   // Random backpressure when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) ifa.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   task automatic accept_op(input logic [31:0] s, input logic [255:0] v);
      bit done;
      ifa.scalar    = s;
      ifa.in_vector = v;
      ifa.in_valid  = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         done = ifa.in_ready;
         @(posedge clk);
         #1;
      end
      ifa.in_valid = 1'b0;
      if (!done) fail("accept_timeout");
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (ifa.out_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) fail("drain_timeout");
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w = {{14{w[17]}}, w[17:0]};
      return w;
   endfunction

   initial begin
      int           lat;
      logic [255:0] v;
      logic [255:0] snap;
      logic [255:0] expv;
      logic [31:0]  s;

      ifa.in_valid = 1'b0; ifa.scalar = '0; ifa.in_vector = '0; ifa.out_ready = 1'b1;
      ifb.in_valid = 1'b0; ifb.scalar = '0; ifb.in_vector = '0; ifb.out_ready = 1'b1;

      // Pin the reference model to hand-computed values
      check("model_basic", ref_mul(32'h0002_0000, 32'h0001_8000, 16), {1'b0, 32'h0003_0000});
      check("model_round_pos", ref_mul(32'h0000_0001, 32'h0000_8000, 16), {1'b0, 32'h0000_0001});
      check("model_round_neg", ref_mul(32'h0000_0001, 32'hFFFF_8000, 16), {1'b0, 32'h0000_0000});
      check("model_int", ref_mul(32'hFFFF_FFFD, 32'h0000_0007, 0), {1'b0, 32'hFFFF_FFEB});

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_state", {ifa.in_ready, ifa.out_valid, ifa.busy, ifa.ovf}, {1'b1, 1'b0, 1'b0, 8'h00});
      check("reset_out_vector", ifa.out_vector, 256'h0);

      // 2.0 x 1.5 on every element, latency N+1 = 5
      accept_op(32'h0002_0000, {8{32'h0001_8000}});
      check("busy_after_accept", {ifa.busy, ifa.in_ready}, 2'b10);
      wait_valid(lat);
      check("latency_n4", 256'(lat), 256'd5);
      check("basic_vector", ifa.out_vector, {8{32'h0003_0000}});
      check("basic_ovf", ifa.ovf, 8'h00);
      wait_drain();

      // Rounding toward +inf
      accept_op(32'h0000_0001, {192'h0, 32'hFFFF_8000, 32'h0000_8000});
      wait_valid(lat);
      check("round_vector", ifa.out_vector, {192'h0, 32'h0000_0000, 32'h0000_0001});
      wait_drain();

      // Overflow: saturate or wrap
      accept_op(32'h7FFF_0000, {192'h0, 32'hFFFE_0000, 32'h0002_0000});
      wait_valid(lat);
`ifdef SVM_SATURATE_EN
      check("ovf_vector", ifa.out_vector, {192'h0, 32'h8000_0000, 32'h7FFF_FFFF});
      check("ovf_flags", ifa.ovf, 8'b0000_0011);
`else
      check("wrap_vector", ifa.out_vector, {192'h0, 32'h0002_0000, 32'hFFFE_0000});
      check("wrap_flags", ifa.ovf, 8'b0000_0000);
`endif
      wait_drain();

      // Backpressure: result holds for 10 cycles, a new request waits
      ifa.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = rand_word();
      accept_op(rand_word(), v);
      wait_valid(lat);
      snap = ifa.out_vector;
      for (int i = 0; i < 10; i++) begin
         check("bp_hold", {ifa.out_valid, ifa.in_ready}, 2'b10);
         check("bp_stable", ifa.out_vector, snap);
         if (i == 1) begin
            for (int j = 0; j < 8; j++) v[j*32 +: 32] = rand_word();
            ifa.scalar    = rand_word();
            ifa.in_vector = v;
            ifa.in_valid  = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      ifa.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", {ifa.in_ready, ifa.out_valid}, 2'b10);
      @(posedge clk);
      #1;
      check("bp_queued_accept", {ifa.busy, ifa.in_ready}, 2'b10);
      ifa.in_valid = 1'b0;
      wait_drain();

      // Reset in the second MULT cycle
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = rand_word();
      accept_op(32'h0001_0000, v);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_status", {ifa.out_valid, ifa.busy, ifa.in_ready, ifa.ovf}, {1'b0, 1'b0, 1'b1, 8'h00});
      check("midrst_vector", ifa.out_vector, 256'h0);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         check("midrst_no_result", 256'(ifa.out_valid), 256'd0);
      end

      // Randomised operations under random backpressure
      rand_rdy = 1'b1;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 8; i++) v[i*32 +: 32] = rand_word();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         accept_op(rand_word(), v);
      end
      rand_rdy = 1'b0;
      ifa.out_ready = 1'b1;
      wait_drain();

      // Integer mode, one chunk: -3 x {0..7}, latency 2
      for (int i = 0; i < 8; i++) begin
         v[i*32 +: 32] = 32'(i);
         expv[i*32 +: 32] = 32'(-3 * i);
      end
      check("int_expect_pin", expv[255:224], 32'hFFFF_FFEB);
      ifb.scalar    = 32'hFFFF_FFFD;
      ifb.in_vector = v;
      ifb.in_valid  = 1'b1;
      lat = -1;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         if (ifb.in_ready) lat = 0;
         @(posedge clk);
         #1;
      end
      ifb.in_valid = 1'b0;
      if (lat < 0) fail("int_accept_timeout");
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (ifb.out_valid) begin
            lat = k;
            break;
         end
      end
      check("int_latency", 256'(lat), 256'd2);
      check("int_vector", ifb.out_vector, expv);
      check("int_ovf", ifb.ovf, 8'h00);
      check("model_int_vec", ref_vec(32'hFFFF_FFFD, v, 0).vec, expv);
      @(posedge clk);
      #1;
      check("int_release", {ifb.out_valid, ifb.in_ready}, 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
